// File: rtl/note_generator_pkg.sv
// Shared constants, note names and helpers for the note generator.
`timescale 1ns/1ps
package note_pkg;

    localparam int NUM_NOTES = 12;
    localparam int CNT_W     = 16;
    localparam int LEVEL_W   = 4;
    localparam int PWM_STEPS = 12;

    typedef enum logic [3:0] {
        NOTE_C,
        NOTE_CS,
        NOTE_D,
        NOTE_DS,
        NOTE_E,
        NOTE_F,
        NOTE_FS,
        NOTE_G,
        NOTE_GS,
        NOTE_A,
        NOTE_AS,
        NOTE_B
    } note_e;

    function automatic logic [LEVEL_W-1:0] popcount(
        input logic [NUM_NOTES-1:0] v
    );
        logic [LEVEL_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            s = s + LEVEL_W'(v[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/note_generator_if.sv
// Key/divider inputs and audio outputs of the note generator.
`timescale 1ns/1ps
interface note_generator_if;
    import note_pkg::*;

    logic [NUM_NOTES-1:0] keys;
    logic [CNT_W-1:0]     div0;
    logic [CNT_W-1:0]     div1;
    logic [CNT_W-1:0]     div2;
    logic [CNT_W-1:0]     div3;
    logic [CNT_W-1:0]     div4;
    logic [CNT_W-1:0]     div5;
    logic [CNT_W-1:0]     div6;
    logic [CNT_W-1:0]     div7;
    logic [CNT_W-1:0]     div8;
    logic [CNT_W-1:0]     div9;
    logic [CNT_W-1:0]     div10;
    logic [CNT_W-1:0]     div11;
    logic [NUM_NOTES-1:0] wave;
    logic [LEVEL_W-1:0]   mix_level;
    logic                 pwm_out;
    logic                 frame_strobe;

    modport master (
        output keys,
        output div0, div1, div2, div3,
        output div4, div5, div6, div7,
        output div8, div9, div10, div11,
        input  wave,
        input  mix_level,
        input  pwm_out,
        input  frame_strobe
    );

    modport slave (
        input  keys,
        input  div0, div1, div2, div3,
        input  div4, div5, div6, div7,
        input  div8, div9, div10, div11,
        output wave,
        output mix_level,
        output pwm_out,
        output frame_strobe
    );

endinterface

// File: rtl/note_generator_tone_channel.sv
// One square-wave channel: counts half periods and toggles its wave bit.
`timescale 1ns/1ps
module tone_channel
    import note_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             wave
);

    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wave_nxt;
    logic             w_wrap;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wave;

    assign w_half = div >> 1;
    // >= rather than == so a shrinking divider wraps at once
    assign w_wrap = (r_cnt >= (w_half - CNT_W'(1)));

    always_comb begin
        w_cnt_nxt  = '0;
        w_wave_nxt = 1'b0;
        if (en && (w_half != '0)) begin
            if (w_wrap) begin
                w_cnt_nxt  = '0;
                w_wave_nxt = ~r_wave;
            end else begin
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                w_wave_nxt = r_wave;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_wave <= w_wave_nxt;
        end
    end

    assign wave = r_wave;

endmodule

// File: rtl/note_generator.sv
// Twelve-note square-wave generator with level mixer and optional PWM.
// PWM output stage is built only with NOTE_GENERATOR_PWM_EN defined.
`timescale 1ns/1ps
module note_generator
    import note_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    note_generator_if.slave bus
);

    logic [CNT_W-1:0]     w_div [NUM_NOTES];
    logic [NUM_NOTES-1:0] w_wave;
    logic [LEVEL_W-1:0]   r_mix_level;

    assign w_div[0]  = bus.div0;
    assign w_div[1]  = bus.div1;
    assign w_div[2]  = bus.div2;
    assign w_div[3]  = bus.div3;
    assign w_div[4]  = bus.div4;
    assign w_div[5]  = bus.div5;
    assign w_div[6]  = bus.div6;
    assign w_div[7]  = bus.div7;
    assign w_div[8]  = bus.div8;
    assign w_div[9]  = bus.div9;
    assign w_div[10] = bus.div10;
    assign w_div[11] = bus.div11;

    for (genvar g = 0; g < NUM_NOTES; g++) begin : g_ch
        tone_channel u_ch (
            .clk  (clk),
            .rst  (rst),
            .en   (bus.keys[g]),
            .div  (w_div[g]),
            .wave (w_wave[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mix_level <= '0;
        end else begin
            r_mix_level <= popcount(w_wave);
        end
    end

    assign bus.wave      = w_wave;
    assign bus.mix_level = r_mix_level;

`ifdef NOTE_GENERATOR_PWM_EN
    localparam logic [LEVEL_W-1:0] PwmLast =
        LEVEL_W'(PWM_STEPS - 1);

    logic [LEVEL_W-1:0] r_pwm_cnt;
    logic [LEVEL_W-1:0] r_frame_level;
    logic [LEVEL_W-1:0] w_pwm_cnt_nxt;
    logic [LEVEL_W-1:0] w_level;
    logic               r_pwm_out;
    logic               r_frame_strobe;

    always_comb begin
        w_pwm_cnt_nxt = r_pwm_cnt + LEVEL_W'(1);
        if (r_pwm_cnt == PwmLast) begin
            w_pwm_cnt_nxt = '0;
        end
        // first step of a frame compares against the value being latched
        w_level = r_frame_level;
        if (r_pwm_cnt == '0) begin
            w_level = r_mix_level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt      <= '0;
            r_frame_level  <= '0;
            r_pwm_out      <= 1'b0;
            r_frame_strobe <= 1'b0;
        end else begin
            r_pwm_cnt      <= w_pwm_cnt_nxt;
            if (r_pwm_cnt == '0) begin
                r_frame_level <= r_mix_level;
            end
            r_pwm_out      <= (r_pwm_cnt < w_level);
            r_frame_strobe <= (w_pwm_cnt_nxt == '0);
        end
    end

    assign bus.pwm_out      = r_pwm_out;
    assign bus.frame_strobe = r_frame_strobe;
`else
    assign bus.pwm_out      = 1'b0;
    assign bus.frame_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_note_generator.sv
// Directed + random bench for note_generator with a cycle scoreboard.
`timescale 1ns/1ps
module tb_note_generator;
    import note_pkg::*;

    typedef struct packed {
        logic [11:0] wave;
        logic [3:0]  mix;
        logic        pwm;
        logic        strb;
    } exp_t;

    logic clk;
    logic rst;
    note_generator_if bus ();

    note_generator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [15:0] t_div [12];
    logic [11:0] t_keys;

    int          m_cnt [12];
    logic [11:0] m_wave  = '0;
    logic [3:0]  m_mix   = '0;
    logic [3:0]  m_pcnt  = '0;
    logic [3:0]  m_latch = '0;
    logic        m_pwm   = 1'b0;
    logic        m_strb  = 1'b0;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.keys  = t_keys;
        bus.div0  = t_div[0];
        bus.div1  = t_div[1];
        bus.div2  = t_div[2];
        bus.div3  = t_div[3];
        bus.div4  = t_div[4];
        bus.div5  = t_div[5];
        bus.div6  = t_div[6];
        bus.div7  = t_div[7];
        bus.div8  = t_div[8];
        bus.div9  = t_div[9];
        bus.div10 = t_div[10];
        bus.div11 = t_div[11];
    endtask

    function automatic logic [3:0] pop12(input logic [11:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 12; i++) s = s + {3'b0, v[i]};
        return s;
    endfunction

    // reference model: advances one rising edge from the driven inputs
    task automatic model_edge();
        logic [11:0] nw;
        logic [3:0]  nmix;
        logic        npwm;
        int          h;
        nw   = '0;
        nmix = pop12(m_wave);
        for (int n = 0; n < 12; n++) begin
            h = int'(t_div[n] >> 1);
            if (rst || !t_keys[n] || h == 0) begin
                m_cnt[n] = 0;
                nw[n]    = 1'b0;
            end else if (m_cnt[n] >= h - 1) begin
                m_cnt[n] = 0;
                nw[n]    = ~m_wave[n];
            end else begin
                m_cnt[n] = m_cnt[n] + 1;
                nw[n]    = m_wave[n];
            end
        end
        m_wave = nw;
`ifdef NOTE_GENERATOR_PWM_EN
        if (rst) begin
            m_pcnt  = '0;
            m_latch = '0;
            m_pwm   = 1'b0;
            m_strb  = 1'b0;
        end else begin
            if (m_pcnt == 4'd0) begin
                npwm    = (m_pcnt < m_mix);
                m_latch = m_mix;
            end else begin
                npwm = (m_pcnt < m_latch);
            end
            m_pcnt = (m_pcnt == 4'd11) ? 4'd0 : m_pcnt + 4'd1;
            m_strb = (m_pcnt == 4'd0);
            m_pwm  = npwm;
        end
`else
        npwm   = 1'b0;
        m_pwm  = npwm;
        m_strb = 1'b0;
`endif
        m_mix = rst ? 4'd0 : nmix;
    endtask

    task automatic cycle();
        exp_t e;
        drive();
        model_edge();
        e = '{wave: m_wave, mix: m_mix, pwm: m_pwm, strb: m_strb};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_wave", {4'b0, bus.wave}, {4'b0, e.wave});
        chk("sb_mix", {12'b0, bus.mix_level}, {12'b0, e.mix});
        chk("sb_pwm", {15'b0, bus.pwm_out}, {15'b0, e.pwm});
        chk("sb_strobe", {15'b0, bus.frame_strobe}, {15'b0, e.strb});
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        int ones;
        int strbs;
        for (int n = 0; n < 12; n++) begin
            t_div[n] = 16'd8;
            m_cnt[n] = 0;
        end
        rst    = 1'b1;
        t_keys = 12'hFFF;
        drive();

        // reset holds everything low even with keys down
        run(3);
        chk("rst_wave", {4'b0, bus.wave}, 16'h0);
        chk("rst_mix", {12'b0, bus.mix_level}, 16'h0);
        chk("rst_pwm", {15'b0, bus.pwm_out}, 16'h0);
        chk("rst_strobe", {15'b0, bus.frame_strobe}, 16'h0);

        // single note, div 8: rise 4 cycles after press
        rst    = 1'b0;
        t_keys = 12'h000;
        run(2);
        t_keys = 12'h001;
        run(3);
        chk("pre_rise", {15'b0, bus.wave[0]}, 16'h0);
        run(1);
        chk("first_rise", {15'b0, bus.wave[0]}, 16'h1);
        run(1);
        chk("mix_lag", {12'b0, bus.mix_level}, 16'h1);
        run(3);
        chk("first_fall", {15'b0, bus.wave[0]}, 16'h0);
        run(12);

        // divider shrinks below current count
        t_keys = 12'h000;
        run(1);
        t_div[0] = 16'd20;
        t_keys   = 12'h001;
        run(7);
        chk("cnt7_low", {15'b0, bus.wave[0]}, 16'h0);
        t_div[0] = 16'd10;
        run(1);
        chk("shrink_wrap", {15'b0, bus.wave[0]}, 16'h1);
        run(4);
        chk("shrink_hold", {15'b0, bus.wave[0]}, 16'h1);
        run(1);
        chk("shrink_next", {15'b0, bus.wave[0]}, 16'h0);
        run(10);

        // degenerate dividers and mid-period release
        t_keys   = 12'h008;
        t_div[3] = 16'd1;
        run(10);
        chk("div1_silent", {15'b0, bus.wave[3]}, 16'h0);
        t_div[3] = 16'd0;
        run(10);
        chk("div0_silent", {15'b0, bus.wave[3]}, 16'h0);
        t_div[3] = 16'd8;
        run(6);
        chk("w3_high", {15'b0, bus.wave[3]}, 16'h1);
        t_keys = 12'h000;
        run(1);
        chk("release_clr", {15'b0, bus.wave[3]}, 16'h0);

        // reset mid-tone with mixed dividers
        for (int n = 0; n < 12; n++) t_div[n] = 16'(4 + 2 * n + (n % 3));
        t_keys = 12'hAF5;
        run(17);
        rst = 1'b1;
        run(1);
        chk("rst_abort", {4'b0, bus.wave}, 16'h0);
        rst = 1'b0;
        run(30);

        // all notes together, div 4
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        for (int n = 0; n < 12; n++) t_div[n] = 16'd4;
        t_keys = 12'hFFF;
        run(2);
        chk("all_high", {4'b0, bus.wave}, 16'h0FFF);
        run(1);
        chk("mix_full", {12'b0, bus.mix_level}, 16'd12);
        run(24);
        ones  = 0;
        strbs = 0;
        repeat (12) begin
            cycle();
            ones  += int'(bus.pwm_out);
            strbs += int'(bus.frame_strobe);
        end
`ifdef NOTE_GENERATOR_PWM_EN
        chk("frame_strobes", 16'(strbs), 16'd1);
        chk("pwm_uniform", {15'b0, (ones == 0 || ones == 12)}, 16'h1);
`else
        chk("frame_strobes", 16'(strbs), 16'd0);
        chk("pwm_tied", 16'(ones), 16'd0);
`endif

        // random keys and small dividers
        repeat (200) begin
            if ($urandom_range(0, 7) == 0) t_keys = 12'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                for (int n = 0; n < 12; n++) begin
                    t_div[n] = 16'($urandom_range(0, 14));
                end
            end
            cycle();
        end

        chk("sb_empty", 16'(sb_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
